// File: rtl/rnd_stream_loader.sv
// rnd_stream_loader: requests ARRAY_LEN words from random_generator and streams them out over valid/ready.
// Build option RND_STREAM_LOADER_XORFOLD_EN folds the weak low LCG bits into the streamed word.
module rnd_stream_loader #(
   parameter int DATA_WDTH = 32,
   parameter int OUT_WDTH  = 16,
   parameter int ARRAY_LEN = 16,
   parameter int CNT_WDTH  = $clog2(ARRAY_LEN+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 gen_enable,
   input  logic [DATA_WDTH-1:0] rnd_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WDTH-1:0]  out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
   localparam logic [CNT_WDTH-1:0] LEN  = CNT_WDTH'(ARRAY_LEN);
   localparam logic [CNT_WDTH-1:0] LAST = CNT_WDTH'(ARRAY_LEN-1);
   state_t              r_state;
   logic [CNT_WDTH-1:0] r_req_cnt;
   logic [CNT_WDTH-1:0] r_xfer_cnt;
   logic                r_pending;
   logic                w_xfer;
   logic                w_unused;
   // A new word is requested only when nothing is waiting or the waiting one leaves this cycle.
   assign gen_enable = (r_state == FILL) && (r_req_cnt < LEN) && (!r_pending || out_ready);
   assign w_xfer     = r_pending && out_ready;
   assign out_valid  = r_pending;
   assign out_last   = r_pending && (r_xfer_cnt == LAST);
   assign busy       = r_state != IDLE;
   assign done       = r_state == DONE;
   assign w_unused   = ^rnd_in;
`ifdef RND_STREAM_LOADER_XORFOLD_EN
   assign out_data = rnd_in[DATA_WDTH-1 -: OUT_WDTH] ^ rnd_in[OUT_WDTH-1:0];
`else
   assign out_data = rnd_in[DATA_WDTH-1 -: OUT_WDTH];
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_req_cnt  <= '0;
         r_xfer_cnt <= '0;
         r_pending  <= 1'b0;
      end else begin
         r_pending <= gen_enable | (r_pending & ~out_ready);
         if (gen_enable) r_req_cnt <= r_req_cnt + 1'b1;
         if (w_xfer) r_xfer_cnt <= r_xfer_cnt + 1'b1;
         case (r_state)
            IDLE: if (start) begin
               r_state    <= FILL;
               r_req_cnt  <= '0;
               r_xfer_cnt <= '0;
               r_pending  <= 1'b0;
            end
            FILL: if (w_xfer && r_xfer_cnt == LAST) r_state <= DONE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rnd_stream_loader.sv
// tb_rnd_stream_loader: directed runs of the loader fed by an LCG generator model, scoreboarded per word.
// A second instance with ARRAY_LEN=1 is driven with random out_ready.
module tb_rnd_stream_loader;
   localparam int LEN = 16;
`ifdef RND_STREAM_LOADER_XORFOLD_EN
   localparam logic [15:0] FIRST_WORD = 16'hE241;
`else
   localparam logic [15:0] FIRST_WORD = 16'h0001;
`endif
   typedef struct packed {logic [15:0] data; logic last;} exp_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start = 1'b0, out_ready = 1'b0, start1 = 1'b0, ready1 = 1'b0;
   logic        gen_enable, out_valid, out_last, busy, done;
   logic        gen1, valid1, last1, busy1, done1;
   logic [15:0] out_data, data1, d1_data, first_data;
   logic [31:0] rnd_in, rnd1, g_seed, g_seed1;
   logic [31:0] ref_seed = 32'd123456;
   exp_t        q[$];
   int errors = 0, checks = 0, cyc_n = 0, words = 0, gens = 0;
   int done_cyc = -1, first_cyc = -1, last_cyc = -1;
   int w1 = 0, g1 = 0, d1 = 0, l1 = 0;

   always #5 clk = ~clk;

   rnd_stream_loader dut (
      .clk(clk), .rst(rst), .start(start), .gen_enable(gen_enable), .rnd_in(rnd_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );
   rnd_stream_loader #(.ARRAY_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .gen_enable(gen1), .rnd_in(rnd1),
      .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_last(last1),
      .busy(busy1), .done(done1)
   );

   // Generator models: registered output, new value one cycle after enable, held otherwise.
   always @(posedge clk) begin
      if (rst) begin
         g_seed <= 32'd123456;
         rnd_in <= '0;
      end else if (gen_enable) begin
         rnd_in <= g_seed;
         g_seed <= g_seed * 32'd1103515245 + 32'd12345;
      end
   end
   always @(posedge clk) begin
      if (rst) begin
         g_seed1 <= 32'd123456;
         rnd1    <= '0;
      end else if (gen1) begin
         rnd1    <= g_seed1;
         g_seed1 <= g_seed1 * 32'd1103515245 + 32'd12345;
      end
   end

   function automatic logic [31:0] lcg(input logic [31:0] x);
      return x * 32'd1103515245 + 32'd12345;
   endfunction

   function automatic logic [15:0] red(input logic [31:0] x);
`ifdef RND_STREAM_LOADER_XORFOLD_EN
      return x[31:16] ^ x[15:0];
`else
      return x[31:16];
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      #1;
      if (gen_enable) gens++;
      if (gen1) g1++;
      if (done1) d1++;
      if (valid1 && ready1) begin
         w1++;
         d1_data = data1;
         l1 += int'(last1);
      end
      if (done && done_cyc < 0) done_cyc = cyc_n;
      if (out_valid && out_ready) begin
         if (first_cyc < 0) begin
            first_cyc  = cyc_n;
            first_data = out_data;
         end
         last_cyc = cyc_n;
         words++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL extra_word: observed %0h expected none", out_data);
         end else begin
            e = q.pop_front();
            chk("word_data", 32'(out_data), 32'(e.data));
            chk("word_last", 32'(out_last), 32'(e.last));
         end
      end
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic run(input int stall_word, input int stall_len, input int restart_at, input int abort_word);
      int stalled = 0;
      logic [15:0] held = '0;
      cyc_n = 0; words = 0; gens = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
      for (int i = 0; i < LEN; i++) begin
         q.push_back(exp_t'({red(ref_seed), i == LEN-1}));
         ref_seed = lcg(ref_seed);
      end
      start = 1'b1;
      out_ready = 1'b1;
      #1 chk("busy_c0", 32'(busy), 0);
      chk("done_c0", 32'(done), 0);
      tick();
      start = 1'b0;
      #1 chk("busy_c1", 32'(busy), 1);
      chk("gen_en_c1", 32'(gen_enable), 1);
      while (done_cyc < 0 && cyc_n < 200) begin
         start = (cyc_n == restart_at);
         if (abort_word > 0 && words == abort_word-1 && out_valid) begin
            rst = 1'b1;
            out_ready = 1'b0;
            tick();
            rst = 1'b0;
            start = 1'b0;
            q.delete();
            ref_seed = 32'd123456;
            #1 chk("rst_gen_en", 32'(gen_enable), 0);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_last", 32'(out_last), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            return;
         end
         if (stall_word > 0 && words == stall_word-1 && out_valid && stalled < stall_len) begin
            if (stalled == 0) held = out_data;
            out_ready = 1'b0;
            stalled++;
            #1 chk("stall_gen_en", 32'(gen_enable), 0);
            chk("stall_data_hold", 32'(out_data), 32'(held));
         end else begin
            out_ready = 1'b1;
         end
         tick();
      end
      start = 1'b0;
      chk("done_cycle", done_cyc, LEN + 2 + stall_len);
      chk("first_word_cycle", first_cyc, 2);
      chk("last_word_cycle", last_cyc, LEN + 1 + stall_len);
      chk("word_count", words, LEN);
      chk("gen_count", gens, LEN);
      chk("queue_empty", q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      #1 chk("reset_gen_en", 32'(gen_enable), 0);
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_last", 32'(out_last), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      rst = 1'b0;
      run(0, 0, -1, 0);
      chk("first_word_value", 32'(first_data), 32'(FIRST_WORD));
      run(3, 5, -1, 0);
      run(0, 0, 6, 0);
      run(0, 0, -1, 7);
      run(0, 0, -1, 0);
      chk("first_word_after_rst", 32'(first_data), 32'(FIRST_WORD));
      #1 chk("final_busy", 32'(busy), 0);
      chk("final_done", 32'(done), 0);
      w1 = 0; g1 = 0; d1 = 0; l1 = 0;
      start1 = 1'b1;
      ready1 = 1'b0;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ready1 = (i >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
      end
      chk("len1_words", w1, 1);
      chk("len1_last", l1, 1);
      chk("len1_gen_cycles", g1, 1);
      chk("len1_done_pulses", d1, 1);
      chk("len1_data", 32'(d1_data), 32'(red(32'd123456)));
      chk("len1_busy_end", 32'(busy1), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
